// File: rtl/up5bit_pwm_stage.sv
// PWM stage fed by a free-running up-counter: checks the count sequence, drives a
// shadow-buffered PWM, tracks wraps/periods and latches a fault after repeated bad steps.
module up5bit_pwm_stage #(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned ERR_LIMIT = 3,
   parameter int unsigned PCNT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  cnt_in,
   input  logic [WIDTH-1:0]  duty_in,
   input  logic              duty_load,
   output logic              pwm_out,
   output logic              wrap_pulse,
   output logic [PCNT_W-1:0] period_cnt,
   output logic              seq_err,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StTrack = 2'd1,
      StFault = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] CntMax   = '1;
   localparam logic [2:0]       ErrLimit = 3'(ERR_LIMIT);

   state_e            state_q;
   logic [WIDTH-1:0]  cnt_prev_q;
   logic [WIDTH-1:0]  duty_shadow_q;
   logic [WIDTH-1:0]  duty_active_q;
   logic [2:0]        err_run_q;
   logic              pwm_q;
   logic              wrap_q;
   logic              seq_err_q;
   logic [PCNT_W-1:0] period_q;

   logic [WIDTH-1:0]  cnt_inc;
   logic              step_good;
   logic              step_hold;
   logic              wrap_seen;
   logic [2:0]        err_next;
   logic [WIDTH-1:0]  duty_next;

   always_comb begin
      cnt_inc   = cnt_prev_q + WIDTH'(1);
      step_good = (cnt_in == cnt_inc);
      step_hold = (cnt_in == cnt_prev_q);
      wrap_seen = (cnt_prev_q == CntMax) && (cnt_in == '0);
      err_next  = err_run_q + 3'd1;
      // A load coinciding with a shadow-to-active copy bypasses the shadow
      duty_next = duty_load ? duty_in : duty_shadow_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_prev_q    <= '0;
         duty_shadow_q <= '0;
         duty_active_q <= '0;
         err_run_q     <= '0;
         pwm_q         <= 1'b0;
         wrap_q        <= 1'b0;
         seq_err_q     <= 1'b0;
         period_q      <= '0;
      end else begin
         if (duty_load) begin
            duty_shadow_q <= duty_in;
         end
         unique case (state_q)
            StIdle: begin
               cnt_prev_q    <= cnt_in;
               duty_active_q <= duty_next;
               err_run_q     <= '0;
               pwm_q         <= 1'b0;
               wrap_q        <= 1'b0;
               state_q       <= StTrack;
            end
            StTrack: begin
               cnt_prev_q <= cnt_in;
               pwm_q      <= (cnt_in < duty_active_q);
               wrap_q     <= wrap_seen;
               if (wrap_seen) begin
                  duty_active_q <= duty_next;
                  if (period_q != '1) begin
                     period_q <= period_q + PCNT_W'(1);
                  end
               end
               if (step_good) begin
                  err_run_q <= '0;
               end else if (!step_hold) begin
                  err_run_q <= err_next;
                  if (err_next == ErrLimit) begin
                     state_q   <= StFault;
                     seq_err_q <= 1'b1;
                     pwm_q     <= 1'b0;
                  end
               end
            end
            StFault: begin
               cnt_prev_q <= cnt_in;
               pwm_q      <= 1'b0;
               wrap_q     <= 1'b0;
               seq_err_q  <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign pwm_out    = pwm_q;
   assign wrap_pulse = wrap_q;
   assign period_cnt = period_q;
   assign seq_err    = seq_err_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_up5bit_pwm_stage.sv
// Self-checking bench for up5bit_pwm_stage: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model held in the bench.
module tb_up5bit_pwm_stage;

   localparam int Limit = 3;

   logic       clk;
   logic       reset;
   logic [4:0] cnt_in;
   logic [4:0] duty_in;
   logic       duty_load;
   logic       pwm_out;
   logic       wrap_pulse;
   logic [7:0] period_cnt;
   logic       seq_err;
   logic [1:0] state_o;

   up5bit_pwm_stage dut (
      .clk        (clk),
      .reset      (reset),
      .cnt_in     (cnt_in),
      .duty_in    (duty_in),
      .duty_load  (duty_load),
      .pwm_out    (pwm_out),
      .wrap_pulse (wrap_pulse),
      .period_cnt (period_cnt),
      .seq_err    (seq_err),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cur     = 0;

   // Behavioural model: 0=idle, 1=tracking, 2=fault
   int m_mode, m_prev, m_err, m_shadow, m_active, m_period;
   bit m_pwm, m_wrap, m_seq;

   function automatic logic [12:0] exp_vec();
      return {m_pwm, m_wrap, 8'(m_period), m_seq, 2'(m_mode)};
   endfunction

   function automatic logic [12:0] obs_vec();
      return {pwm_out, wrap_pulse, period_cnt, seq_err, state_o};
   endfunction

   task automatic step(input bit r, input int c, input bit ld, input int d);
      int  diff;
      bit  wrapped;
      reset     = r;
      cnt_in    = 5'(c);
      duty_load = ld;
      duty_in   = 5'(d);
      if (r) begin
         m_mode = 0; m_prev = 0; m_err = 0; m_shadow = 0; m_active = 0;
         m_pwm = 0; m_wrap = 0; m_period = 0; m_seq = 0;
      end else begin
         if (m_mode == 0) begin
            m_prev   = c;
            m_active = ld ? d : m_shadow;
            m_pwm    = 0;
            m_wrap   = 0;
            m_mode   = 1;
         end else if (m_mode == 1) begin
            diff    = (c - m_prev + 32) % 32;
            wrapped = (m_prev == 31) && (c == 0);
            m_pwm   = (c < m_active);
            m_wrap  = wrapped;
            if (wrapped) begin
               m_active = ld ? d : m_shadow;
               if (m_period < 255) m_period++;
            end
            if (diff == 1) m_err = 0;
            else if (diff != 0) begin
               m_err++;
               if (m_err == Limit) begin
                  m_mode = 2; m_seq = 1; m_pwm = 0;
               end
            end
            m_prev = c;
         end else begin
            m_pwm = 0; m_wrap = 0; m_seq = 1;
         end
         if (ld) m_shadow = d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input bit ld, input int d);
      step(0, cur, ld, d);
      cur = (cur + 1) % 32;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         n_total++;
         if (obs_vec() !== 13'd0) $display("FAIL reset: outputs=%h required=0", obs_vec());
         else n_pass++;
      end
      cur = 0;
   endtask

   task automatic test_free_run();
      int highs = 0;
      tick(1, 8);
      for (int i = 1; i < 70; i++) begin
         tick(0, 0);
         if (i >= 32 && i < 64) highs += int'(pwm_out);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL free_run cyc %0d: got %h required %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_total++;
      if (highs != 8) $display("FAIL duty8_highs: got %0d required 8", highs);
      else n_pass++;
      n_total++;
      if (period_cnt !== 8'd2 || seq_err !== 1'b0)
         $display("FAIL free_run_end: period=%0d seq_err=%b required 2/0", period_cnt, seq_err);
      else n_pass++;
   endtask

   task automatic test_duty_shadow();
      int highs_old = 0, highs20 = 0, highs31 = 0;
      while (cur != 10) tick(0, 0);
      tick(1, 20);
      while (cur != 0) begin
         tick(0, 0);
         highs_old += int'(pwm_out);
      end
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 32; k++) begin
            tick((p == 1 && k == 0), 31);
            if (p == 0) highs20 += int'(pwm_out);
            else highs31 += int'(pwm_out);
            n_total++;
            if (obs_vec() !== exp_vec())
               $display("FAIL duty_shadow p%0d k%0d: got %h required %h", p, k, obs_vec(),
                        exp_vec());
            else n_pass++;
         end
      end
      n_total++;
      if (highs_old != 0) $display("FAIL old_duty_rest: got %0d required 0", highs_old);
      else n_pass++;
      n_total++;
      if (highs20 != 20) $display("FAIL duty20_highs: got %0d required 20", highs20);
      else n_pass++;
      n_total++;
      if (highs31 != 31) $display("FAIL duty31_bypass_highs: got %0d required 31", highs31);
      else n_pass++;
   endtask

   task automatic test_fault();
      int seq_vals[10] = '{9, 10, 20, 3, 4, 15, 16, 25, 2, 18};
      while (cur != 5) tick(0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, seq_vals[i], 0, 0);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL fault_seq %0d: got %h required %h", i, obs_vec(), exp_vec());
         else n_pass++;
         if (i == 6) begin
            n_total++;
            if (state_o !== 2'd1) $display("FAIL no_early_fault: state=%0d required 1", state_o);
            else n_pass++;
         end
      end
      cur = 19;
      for (int i = 0; i < 16; i++) begin
         tick((i == 3), 30);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL fault_hold %0d: got %h required %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_total++;
      if (state_o !== 2'd2 || seq_err !== 1'b1 || pwm_out !== 1'b0)
         $display("FAIL fault_terminal: state=%0d seq=%b pwm=%b required 2/1/0",
                  state_o, seq_err, pwm_out);
      else n_pass++;
   endtask

   task automatic test_hold_saturate();
      logic pwm_before;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      cur = 0;
      tick(1, 16);
      while (cur != 13) tick(0, 0);
      pwm_before = pwm_out;
      for (int i = 0; i < 10; i++) begin
         step(0, 12, 0, 0);
         n_total++;
         if (pwm_out !== pwm_before || wrap_pulse !== 1'b0 || state_o !== 2'd1)
            $display("FAIL hold %0d: pwm=%b wrap=%b state=%0d required %b/0/1", i, pwm_out,
                     wrap_pulse, state_o, pwm_before);
         else n_pass++;
      end
      for (int i = 0; i < 256 * 32 + 64; i++) begin
         tick(0, 0);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL saturate cyc %0d: got %h required %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_total++;
      if (period_cnt !== 8'd255) $display("FAIL period_sat: got %0d required 255", period_cnt);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      while (cur != 17) tick(0, 0);
      step(1, 17, 0, 0);
      n_total++;
      if (obs_vec() !== 13'd0) $display("FAIL mid_reset: outputs=%h required 0", obs_vec());
      else n_pass++;
      cur = 0;
      for (int i = 0; i < 40; i++) begin
         tick((i == 0), 12);
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL after_reset %0d: got %h required %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_total++;
      if (state_o !== 2'd1 || seq_err !== 1'b0)
         $display("FAIL retrack: state=%0d seq=%b required 1/0", state_o, seq_err);
      else n_pass++;
   endtask

   task automatic test_random();
      int last = cur;
      int v;
      int sel;
      bit r;
      for (int i = 0; i < 4000; i++) begin
         sel = int'($urandom_range(0, 999));
         r   = (sel < 8);
         if (sel < 700) v = (last + 1) % 32;
         else if (sel < 880) v = last;
         else v = int'($urandom_range(0, 31));
         step(r, v, ($urandom_range(0, 9) < 2), int'($urandom_range(0, 31)));
         last = v;
         n_total++;
         if (obs_vec() !== exp_vec())
            $display("FAIL random cyc %0d: got %h required %h", i, obs_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1; cnt_in = '0; duty_in = '0; duty_load = 1'b0;
      test_reset();
      test_free_run();
      test_duty_shadow();
      test_fault();
      test_hold_saturate();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
